audio_receive: RTL
==================

# audio_receive

Serial-to-parallel I2S receiver for the codec ADC path; the receive-direction counterpart of the DAC serializer. Clocked directly by the codec bit clock, it samples `aud_adcdat` on rising `aud_bclk`, frames words on `aud_lrc` transitions, pairs left and right words into stereo frames, and hands them to user logic through a one-deep valid/ready register with sticky overrun reporting.

## Interface
- `WL`, default 32: word length in bits; legal range 16–32.
- `aud_bclk`  in  1  codec bit clock; sole clock, all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `aud_lrc`  in  1  word-select: low = left, high = right.
- `aud_adcdat`  in  1  serial ADC data, MSB first, driven by the codec on falling `aud_bclk`.
- `adc_data_l`  out  32  left sample of the held frame.
- `adc_data_r`  out  32  right sample of the held frame.
- `adc_valid`  out  1  held frame valid.
- `adc_ready`  in  1  consumer accepts the frame when `adc_valid && adc_ready` at a rising edge.
- `rx_done`  out  1  one-cycle pulse per completed word, either channel.
- `rx_overrun`  out  1  sticky: a completed frame was dropped.

## Operation
- `lrc_d0` holds `aud_lrc` delayed one edge. `lrc_edge = aud_lrc ^ lrc_d0`.
- Bit counter `rx_cnt`, 6 bits. Reset value `WL`, so the block is idle until the first `lrc_edge`.
- At an edge with `lrc_edge`: `rx_cnt <= 0`. Any partial word is discarded with no `rx_done`.
- At an edge with no `lrc_edge` and `rx_cnt < WL`:
  - shift in `aud_adcdat` (MSB first);
  - `rx_cnt <= rx_cnt + 1`.
- `rx_cnt == WL` means the counter saturates. Further bits in the slot are ignored.
- Word completes at the edge where `rx_cnt` goes `WL-1 -> WL`. Channel comes from `lrc_d0` at that edge.
- Left word: written to the pending-left register; sets `left_ok`.
- Right word with `left_ok == 1`: forms frame {pending-left, right}; clears `left_ok`.
- Right word with `left_ok == 0` (e.g. first word after reset): discarded; `rx_done` still pulses.
- Frame load into the output register:
  - if `!adc_valid`, or `adc_ready` in the same cycle: load the frame, `adc_valid <= 1`;
  - else: keep the held frame, drop the new one, `rx_overrun <= 1`.
- Handshake with no new frame: `adc_valid <= 0`.
- Output data is stable while `adc_valid && !adc_ready`.
- `rx_overrun` is cleared only by `rst`.
- Output width: received bits occupy `[WL-1:0]`. Bits `[31:WL]` are filled per Configuration.
- Reset mid-word or mid-handshake:
  - all state is cleared immediately;
  - the held frame and pending left word are lost;
  - reception restarts at the next `lrc_edge`.
- Reset values: `adc_data_l = 0`, `adc_data_r = 0`, `adc_valid = 0`, `rx_done = 0`, `rx_overrun = 0`, `rx_cnt = WL`, `left_ok = 0`, `lrc_d0 = 0`.

## Timing
- `aud_lrc` toggles; edge P0 detects `lrc_edge`. Bits MSB..LSB are sampled at edges P1..PWL (one-bclk I2S delay).
- `rx_done` is high for the single cycle after PWL.
- For a right word, `adc_valid` and the new data are visible after PWL, in the same cycle as `rx_done`.
- Latency from sampling the LSB to valid: 0 additional edges.
- `adc_ready` is never required. Throughput is one frame per LRC period. Holding valid for more than one LRC period without `adc_ready` causes overrun.

## Configuration
- `AUDIO_RX_SIGN_EXT_EN` defined: bits `[31:WL]` of each output word copy bit `WL-1` (two's-complement sign extension).
- Not defined: bits `[31:WL]` are zero.
- With `WL == 32` the two behaviours are identical.

## Structure
- Shared package `audio_pkg`:
  - default `WL`;
  - counter width constant (6);
  - channel constants `CH_LEFT = 0`, `CH_RIGHT = 1`.
- One sub-module, `audio_rx_shift`: owns `lrc_d0`, `rx_cnt`, the shift register and word-complete/channel strobes.
- The top level owns left/right pairing, the output register, handshake, overrun and extension.

## Test plan
- `WL=24`, no macro, continuous `adc_ready=1`: send L=`0x800001`, R=`0x7FFFFF` -> `adc_data_l=0x00800001`, `adc_data_r=0x007FFFFF`, `adc_valid` high one cycle after the right LSB edge, two `rx_done` pulses.
- Same stimulus with `AUDIO_RX_SIGN_EXT_EN` -> `adc_data_l=0xFF800001`, `adc_data_r=0x007FFFFF`.
- `WL=32`, `adc_ready=0` for two frames (first `0x12345678/0x9ABCDEF0`) -> first frame held unchanged, `rx_overrun=1` after the second right word; assert `adc_ready` -> `adc_valid` falls, `rx_overrun` stays 1.
- `adc_ready` asserted exactly at the edge a new frame completes while valid -> old frame accepted, new frame loaded, `adc_valid` stays 1, no overrun.
- `aud_lrc` toggles after only 10 bits of a left word -> no `rx_done` and no frame for that word; the next full L/R pair is received correctly.
- Reset first in the right-channel slot, then `rst` pulsed mid-left-word -> no frame until a complete left then right; all outputs 0 during and right after reset.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the codec audio receive path.
package audio_pkg;

  localparam int   WL_DEFAULT = 32;
  localparam int   CNT_W      = 6;
  localparam logic CH_LEFT    = 1'b0;
  localparam logic CH_RIGHT   = 1'b1;

  // Fills bits [31:wl] with either zero or the word's MSB.
  function automatic logic [31:0] extend_word(input logic [31:0] w, input int wl,
                                              input logic sign_en);
    logic [31:0] r;
    logic        fill;
    fill = sign_en & w[wl-1];
    for (int i = 0; i < 32; i++) begin
      r[i] = (i < wl) ? w[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_rx_shift.sv
// I2S bit framing: LRC edge detect, saturating bit counter, MSB-first shift register.
module audio_rx_shift
  import audio_pkg::*;
#(
  parameter int WL = WL_DEFAULT
) (
  input  logic        aud_bclk,
  input  logic        rst,
  input  logic        aud_lrc,
  input  logic        aud_adcdat,
  output logic        word_done,
  output logic        word_ch,
  output logic [31:0] word_data
);

  localparam logic [CNT_W-1:0] WL_C = CNT_W'(WL);

  logic             lrc_d0_q, lrc_d0_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic             lrc_edge;

  always_comb begin
    lrc_edge  = aud_lrc ^ lrc_d0_q;
    lrc_d0_d  = aud_lrc;
    rx_cnt_d  = rx_cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    if (lrc_edge) begin
      rx_cnt_d = '0;
    end else if (rx_cnt_q < WL_C) begin
      shift_d   = {shift_q[30:0], aud_adcdat};
      rx_cnt_d  = rx_cnt_q + CNT_W'(1);
      word_done = (rx_cnt_q == WL_C - CNT_W'(1));
    end
    // The word includes the bit being sampled now, so the top sees it on this edge.
    word_ch   = lrc_d0_q;
    word_data = shift_d;
  end

  always_ff @(posedge aud_bclk or posedge rst) begin
    if (rst) begin
      lrc_d0_q <= 1'b0;
      rx_cnt_q <= WL_C;
      shift_q  <= '0;
    end else begin
      lrc_d0_q <= lrc_d0_d;
      rx_cnt_q <= rx_cnt_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/audio_receive.sv
// I2S ADC receiver: pairs left/right words into frames behind a one-deep valid/ready register.
// Define AUDIO_RX_SIGN_EXT_EN to sign-extend words shorter than 32 bits (else zero-fill).
module audio_receive
  import audio_pkg::*;
#(
  parameter int WL = WL_DEFAULT
) (
  input  logic        aud_bclk,
  input  logic        rst,
  input  logic        aud_lrc,
  input  logic        aud_adcdat,
  output logic [31:0] adc_data_l,
  output logic [31:0] adc_data_r,
  output logic        adc_valid,
  input  logic        adc_ready,
  output logic        rx_done,
  output logic        rx_overrun
);

`ifdef AUDIO_RX_SIGN_EXT_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  logic        word_done, word_ch;
  logic [31:0] word_data, word_ext;
  logic        frame_new;

  logic [31:0] pend_l_q, pend_l_d;
  logic        left_ok_q, left_ok_d;
  logic [31:0] data_l_q, data_l_d;
  logic [31:0] data_r_q, data_r_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;

  audio_rx_shift #(.WL(WL)) u_shift (
    .aud_bclk  (aud_bclk),
    .rst       (rst),
    .aud_lrc   (aud_lrc),
    .aud_adcdat(aud_adcdat),
    .word_done (word_done),
    .word_ch   (word_ch),
    .word_data (word_data)
  );

  always_comb begin
    pend_l_d  = pend_l_q;
    left_ok_d = left_ok_q;
    data_l_d  = data_l_q;
    data_r_d  = data_r_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    done_d    = word_done;
    frame_new = 1'b0;
    word_ext  = extend_word(word_data, WL, SIGN_EXT);

    if (word_done) begin
      if (word_ch == CH_LEFT) begin
        pend_l_d  = word_ext;
        left_ok_d = 1'b1;
      end else if (left_ok_q) begin
        frame_new = 1'b1;
        left_ok_d = 1'b0;
      end
    end

    // A consumer taking the old frame on this edge frees the slot for the new one.
    if (frame_new) begin
      if (!valid_q || adc_ready) begin
        data_l_d = pend_l_q;
        data_r_d = word_ext;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && adc_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aud_bclk or posedge rst) begin
    if (rst) begin
      pend_l_q  <= '0;
      left_ok_q <= 1'b0;
      data_l_q  <= '0;
      data_r_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pend_l_q  <= pend_l_d;
      left_ok_q <= left_ok_d;
      data_l_q  <= data_l_d;
      data_r_q  <= data_r_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_data_l = data_l_q;
  assign adc_data_r = data_r_q;
  assign adc_valid  = valid_q;
  assign rx_done    = done_q;
  assign rx_overrun = overrun_q;

endmodule
